// File: rtl/fht_result_reader_pkg.sv
// Shared types and helpers for the FHT result reader: FSM state encoding,
// group count and the bank-address bit reversal.
package fht_result_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEF_A_BIT = 8;
    localparam int unsigned GROUP_CNT = 1 << DEF_A_BIT;

    localparam int unsigned REV_W  = 16;
    localparam int unsigned REV_IW = 4;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [REV_W-1:0] bit_rev(input logic [REV_W-1:0] v,
                                                 input int unsigned w);
        logic [REV_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REV_W; i++) begin
            if (i < w) begin
                r[REV_IW'(i)] = v[REV_IW'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_result_reader_if.sv
// Handshake/bus bundle between fht_result_reader (master) and its
// environment: start, bank read port and the sample output stream.
interface fht_result_reader_if #(
    parameter int unsigned D_BIT = 16,
    parameter int unsigned A_BIT = 8
);
    logic                    iSTART;
    logic [A_BIT-1:0]        oADDR_RD;
    logic signed [D_BIT-1:0] iDATA_0;
    logic signed [D_BIT-1:0] iDATA_1;
    logic signed [D_BIT-1:0] iDATA_2;
    logic signed [D_BIT-1:0] iDATA_3;
    logic signed [D_BIT-1:0] oDATA;
    logic                    oVALID;
    logic                    iREADY;
    logic [A_BIT+1:0]        oIDX;
    logic                    oLAST;
    logic                    oBUSY;
    logic                    oDONE;

    modport master (
        input  iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        output oADDR_RD, oDATA, oVALID, oIDX, oLAST, oBUSY, oDONE
    );

    modport slave (
        output iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        input  oADDR_RD, oDATA, oVALID, oIDX, oLAST, oBUSY, oDONE
    );
endinterface

// File: rtl/fht_rd_pingpong.sv
// Two 4-word group buffers: one is emitted word by word while the other
// is filled; the output sample is registered from the next-state view.
module fht_rd_pingpong
    import fht_result_reader_pkg::*;
#(
    parameter int unsigned D_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [D_BIT-1:0] d0,
    input  logic [D_BIT-1:0] d1,
    input  logic [D_BIT-1:0] d2,
    input  logic [D_BIT-1:0] d3,
    input  logic             ready,
    output logic             out_valid,
    output logic [D_BIT-1:0] out_data,
    output logic             xfer_c,
    output logic             release_c,
    output logic [1:0]       n_valid_c
);

    typedef logic [3:0][D_BIT-1:0] group_t;

    group_t     grp_q [2];
    group_t     grp_n [2];
    logic [1:0] vld_q, vld_n;
    logic       rd_q, rd_n;
    logic       wr_q, wr_n;
    logic [1:0] word_q, word_n;

    assign xfer_c    = out_valid & ready;
    assign release_c = xfer_c & (word_q == 2'd3);
    assign n_valid_c = 2'(vld_q[0]) + 2'(vld_q[1]);

    // Release happens before capture so a buffer can be refilled on the
    // same edge its last word leaves.
    always_comb begin
        grp_n  = grp_q;
        vld_n  = vld_q;
        rd_n   = rd_q;
        wr_n   = wr_q;
        word_n = word_q;
        if (xfer_c) begin
            if (word_q == 2'd3) begin
                vld_n[rd_q] = 1'b0;
                rd_n        = ~rd_q;
                word_n      = 2'd0;
            end else begin
                word_n = 2'(word_q + 2'd1);
            end
        end
        if (cap) begin
            grp_n[wr_q] = {d3, d2, d1, d0};
            vld_n[wr_q] = 1'b1;
            wr_n        = ~wr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q[0]  <= '0;
            grp_q[1]  <= '0;
            vld_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            word_q    <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            grp_q[0]  <= grp_n[0];
            grp_q[1]  <= grp_n[1];
            vld_q     <= vld_n;
            rd_q      <= rd_n;
            wr_q      <= wr_n;
            word_q    <= word_n;
            out_valid <= vld_n[rd_n];
            out_data  <= grp_n[rd_n][word_n];
        end
    end

endmodule

// File: rtl/fht_result_reader.sv
// Reads one FHT frame out of four result banks and streams it in natural
// order. Bit-reversed bank addressing is enabled by READER_BIT_REV_EN.
module fht_result_reader
    import fht_result_reader_pkg::*;
#(
    parameter int unsigned D_BIT = 16,
    parameter int unsigned A_BIT = 8
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    fht_result_reader_if.master    bus
);

    state_t             state_q, state_n;
    logic [A_BIT-1:0]   grp_q;
    logic [A_BIT-1:0]   addr_q;
    logic [A_BIT-1:0]   bank_addr_c;
    logic [A_BIT+1:0]   idx_q, idx_n;
    logic               last_q, busy_q, done_q;
    logic               pend1_q, pend2_q;
    logic               issue_c, done_c, credit_ok_c, last_grp_c;
    logic [2:0]         used_c;
    logic               xfer_c, release_c, out_valid;
    logic [1:0]         n_valid_c;
    logic [D_BIT-1:0]   out_data;

    fht_rd_pingpong #(.D_BIT(D_BIT)) u_pingpong (
        .clk       (iCLK),
        .rst       (iRESET),
        .cap       (pend2_q),
        .d0        (bus.iDATA_0),
        .d1        (bus.iDATA_1),
        .d2        (bus.iDATA_2),
        .d3        (bus.iDATA_3),
        .ready     (bus.iREADY),
        .out_valid (out_valid),
        .out_data  (out_data),
        .xfer_c    (xfer_c),
        .release_c (release_c),
        .n_valid_c (n_valid_c)
    );

    // Buffer slots already claimed by in-flight reads and held groups.
    assign used_c      = 3'(pend1_q) + 3'(pend2_q) + 3'(n_valid_c) - 3'(release_c);
    assign credit_ok_c = (used_c < 3'd2);
    assign last_grp_c  = (grp_q == {A_BIT{1'b1}});
    assign idx_n       = xfer_c ? (A_BIT+2)'(idx_q + 1'b1) : idx_q;

`ifdef READER_BIT_REV_EN
    assign bank_addr_c = A_BIT'(bit_rev(REV_W'(grp_q), A_BIT));
`else
    assign bank_addr_c = grp_q;
`endif

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:  if (bus.iSTART) state_n = ST_READ;
            ST_READ:  if (credit_ok_c && last_grp_c) state_n = ST_DRAIN;
            ST_DRAIN: if (xfer_c && last_q) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE:  issue_c = bus.iSTART;
            ST_READ:  issue_c = credit_ok_c;
            ST_DRAIN: done_c  = xfer_c & last_q;
            default:  ;
        endcase
    end

    // Address/group counters, read pipeline and status outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            grp_q   <= '0;
            addr_q  <= '0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (issue_c) begin
                addr_q <= bank_addr_c;
                grp_q  <= A_BIT'(grp_q + 1'b1);
            end
            pend1_q <= issue_c;
            pend2_q <= pend1_q;
            idx_q   <= idx_n;
            last_q  <= (idx_n == {(A_BIT+2){1'b1}});
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_c;
        end
    end

    assign bus.oADDR_RD = addr_q;
    assign bus.oDATA    = out_data;
    assign bus.oVALID   = out_valid;
    assign bus.oIDX     = idx_q;
    assign bus.oLAST    = last_q;
    assign bus.oBUSY    = busy_q;
    assign bus.oDONE    = done_q;

endmodule

// File: tb/tb_fht_result_reader.sv
// Scoreboard bench for fht_result_reader (A_BIT=3, D_BIT=16): expected
// samples are queued on frame start and checked by a negedge monitor.
module tb_fht_result_reader;

    localparam int unsigned DB = 16;
    localparam int unsigned AB = 3;
    localparam int          NS = 4 << AB;

    typedef struct {
        int k;
        int data;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rmode = 0;
    int   ph = 0;
    exp_t sb[$];
    bit   tb_busy = 1'b0;
    int   frame_x = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   last_cyc = -100;
    bit   prev_stall = 1'b0;
    int   prev_data, prev_idx, prev_last;

    fht_result_reader_if #(.D_BIT(DB), .A_BIT(AB)) bus ();

    fht_result_reader #(.D_BIT(DB), .A_BIT(AB)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank memories: word a of bank b holds 100*b+a, one-cycle read latency.
    always @(posedge clk) begin
        bus.iDATA_0 <= 16'(0   + int'(bus.oADDR_RD));
        bus.iDATA_1 <= 16'(100 + int'(bus.oADDR_RD));
        bus.iDATA_2 <= 16'(200 + int'(bus.oADDR_RD));
        bus.iDATA_3 <= 16'(300 + int'(bus.oADDR_RD));
    end

    function automatic int rev_grp(input int g);
        int r = 0;
        for (int i = 0; i < int'(AB); i++)
            if (((g >> i) & 1) != 0) r = r | (1 << (int'(AB) - 1 - i));
        return r;
    endfunction

    function automatic int map_grp(input int g);
`ifdef READER_BIT_REV_EN
        return rev_grp(g);
`else
        return g;
`endif
    endfunction

    function automatic int exp_val(input int k);
        return 100 * (k % 4) + map_grp(k / 4);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Ready pattern generator.
    initial begin
        bus.iREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.iREADY = 1'b1;
                1: bus.iREADY = ((ph % 4) == 0) || ((ph % 4) == 3);
                default: bus.iREADY = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: scoreboard pops, stall stability, done timing, prefetch bound.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", int'(bus.oVALID), 1);
                    chk("stall_data", int'(bus.oDATA), prev_data);
                    chk("stall_idx", int'(bus.oIDX), prev_idx);
                    chk("stall_last", int'(bus.oLAST), prev_last);
                end
                if (tb_busy) begin
                    chk("addr_ahead", int'(map_grp(int'(bus.oADDR_RD)) <= frame_x / 4 + 2), 1);
                end
                if (bus.oDONE) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("done_after_last", cyc, last_cyc + 1);
                end
                if (bus.oVALID && bus.iREADY) begin
                    chk("sb_nonempty", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("data", int'(bus.oDATA), e.data);
                        chk("idx", int'(bus.oIDX), e.k);
                        chk("last", int'(bus.oLAST), e.last);
                        frame_x++;
                        if (e.last != 0) begin
                            tb_busy  = 1'b0;
                            last_cyc = cyc;
                        end
                    end
                end
                prev_stall = bus.oVALID && !bus.iREADY;
                prev_data  = int'(bus.oDATA);
                prev_idx   = int'(bus.oIDX);
                prev_last  = int'(bus.oLAST);
            end
        end
    end

    task automatic push_frame();
        for (int k = 0; k < NS; k++) begin
            exp_t e;
            e.k    = k;
            e.data = exp_val(k);
            e.last = (k == NS - 1) ? 1 : 0;
            sb.push_back(e);
        end
        tb_busy = 1'b1;
        frame_x = 0;
    endtask

    // One-cycle start pulse; returns the cycle count right after the sampling edge.
    task automatic start_frame(output int c0);
        bit acc;
        @(posedge clk);
        #1 bus.iSTART = 1'b1;
        acc = !tb_busy;
        @(posedge clk);
        #1 bus.iSTART = 1'b0;
        if (acc) push_frame();
        c0 = cyc;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (tb_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", int'(tb_busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c0;
        int n;
        bus.iSTART = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(bus.oVALID), 0);
        chk("rst_busy", int'(bus.oBUSY), 0);
        chk("rst_done", int'(bus.oDONE), 0);
        chk("rst_last", int'(bus.oLAST), 0);
        chk("rst_addr", int'(bus.oADDR_RD), 0);
        chk("rst_idx", int'(bus.oIDX), 0);
        chk("rst_data", int'(bus.oDATA), 0);

        // Frame 1: ready held high, latency and gap-free streaming.
        rmode = 0;
        start_frame(c0);
        @(negedge clk);
        chk("lat_busy", int'(bus.oBUSY), 1);
        chk("lat_addr0", int'(bus.oADDR_RD), map_grp(0));
        chk("lat_valid_e0", int'(bus.oVALID), 0);
        @(negedge clk);
        chk("lat_addr1", int'(bus.oADDR_RD), map_grp(1));
        chk("lat_valid_e1", int'(bus.oVALID), 0);
        @(negedge clk);
        chk("lat_valid_e2", int'(bus.oVALID), 1);
        chk("lat_idx_e2", int'(bus.oIDX), 0);
        wait_idle(200);
        chk("f1_xfers", frame_x, NS);
        chk("f1_done_cyc", done_cyc, c0 + NS + 2);
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_busy_end", int'(bus.oBUSY), 0);

        // Frame 2: ready pattern 1,0,0,1.
        rmode = 1;
        start_frame(c0);
        wait_idle(400);
        chk("f2_xfers", frame_x, NS);
        chk("f2_done_cnt", done_cnt, 2);

        // Frame 3: random ready with an ignored restart mid-frame.
        rmode = 2;
        start_frame(c0);
        repeat (15) @(posedge clk);
        start_frame(c0);
        wait_idle(600);
        chk("f3_xfers", frame_x, NS);
        chk("f3_done_cnt", done_cnt, 3);

        // Frame 4: new start after done restarts at index 0.
        rmode = 0;
        start_frame(c0);
        wait_idle(200);
        chk("f4_xfers", frame_x, NS);
        chk("f4_done_cnt", done_cnt, 4);

        // Abort after 10 transfers; start coincident with reset is ignored.
        start_frame(c0);
        n = 0;
        while (frame_x < 10 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reach10", frame_x, 10);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.iSTART = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.iSTART = 1'b0;
        sb.delete();
        tb_busy = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(bus.oVALID), 0);
        chk("abort_busy", int'(bus.oBUSY), 0);
        chk("abort_idx", int'(bus.oIDX), 0);
        @(negedge clk);
        chk("rst_start_ignored", int'(bus.oBUSY), 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt, 4);

        // Reset pulse then start on the first clock after release.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.iSTART = 1'b1;
        @(posedge clk);
        #1 bus.iSTART = 1'b0;
        push_frame();
        @(negedge clk);
        chk("post_rst_busy", int'(bus.oBUSY), 1);
        rmode = 2;
        wait_idle(600);
        chk("f6_xfers", frame_x, NS);
        chk("f6_done_cnt", done_cnt, 5);
        chk("sb_empty", int'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
